// File: rtl/vga_game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_game_pkg
//  Description : Screen geometry, object limits, motion FSM encoding and the
//                clamped axis-step helper for the VGA game.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_game_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int BORDER   = 10;
  localparam int OBJ_SIZE = 30;

  localparam int X_MIN_DEF = BORDER;
  localparam int X_MAX_DEF = H_ACTIVE - BORDER - OBJ_SIZE;
  localparam int Y_MIN_DEF = BORDER;
  localparam int Y_MAX_DEF = V_ACTIVE - BORDER - OBJ_SIZE;

  localparam int POS_W  = 10;
  localparam int CALC_W = 11;

  localparam logic [0:0] ST_WAIT  = 1'b0;
  localparam logic [0:0] ST_APPLY = 1'b1;

  // at_edge bit positions: {left, right, top, bottom}
  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_RIGHT  = 2;
  localparam int EDGE_TOP    = 1;
  localparam int EDGE_BOTTOM = 0;

  typedef enum logic [1:0] {
    AXIS_HOLD = 2'd0,
    AXIS_DEC  = 2'd1,
    AXIS_INC  = 2'd2
  } axis_cmd_e;

  function automatic axis_cmd_e axis_cmd(input logic dec_pressed, input logic inc_pressed);
    axis_cmd_e cmd;
    cmd = AXIS_HOLD;
    if (dec_pressed && !inc_pressed) cmd = AXIS_DEC;
    if (inc_pressed && !dec_pressed) cmd = AXIS_INC;
    return cmd;
  endfunction

  // One extra bit of headroom keeps pos+step and min+step from wrapping.
  function automatic logic [POS_W-1:0] axis_step(
    input logic [POS_W-1:0]  pos,
    input axis_cmd_e         cmd,
    input logic [CALC_W-1:0] step,
    input logic [CALC_W-1:0] lo,
    input logic [CALC_W-1:0] hi
  );
    logic [CALC_W-1:0] pos_ext;
    logic [CALC_W-1:0] res;
    pos_ext = {1'b0, pos};
    res     = pos_ext;
    case (cmd)
      AXIS_DEC: res = (pos_ext >= lo + step) ? pos_ext - step : lo;
      AXIS_INC: res = (pos_ext + step <= hi) ? pos_ext + step : hi;
      default:  res = pos_ext;
    endcase
    return res[POS_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/object_motion_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : object_motion_ctrl_if
//  Description : Switch / vsync inputs and object position outputs.
//  Revision    : 1.0  initial release
// ============================================================================
interface object_motion_ctrl_if;
  import vga_game_pkg::*;

  logic             up_switch;
  logic             dn_switch;
  logic             left_switch;
  logic             right_switch;
  logic             VS;
  logic [POS_W-1:0] o_x;
  logic [POS_W-1:0] o_y;
  logic             moving;
  logic [3:0]       at_edge;

  modport master (
    output up_switch, dn_switch, left_switch, right_switch, VS,
    input  o_x, o_y, moving, at_edge
  );

  modport slave (
    input  up_switch, dn_switch, left_switch, right_switch, VS,
    output o_x, o_y, moving, at_edge
  );

endinterface
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debounce
//  Description : 2-flop synchronizer plus stable-count debouncer, idle high.
//  Revision    : 1.0  initial release
// ============================================================================
module switch_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  wire logic CLK,
  input  wire logic RST,
  input  wire logic i_sw,
  output logic      o_sw_deb
);

  localparam int             CNT_W      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_deb   <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
      // The counter only survives an unbroken run of disagreeing samples.
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  assign o_sw_deb = r_deb;

endmodule
`default_nettype wire

// File: rtl/object_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : object_motion_ctrl
//  Description : Debounced switch driven object motion, one clamped step per
//                FRAME_DIV vsync falling edges, applied during vertical blank.
//  Revision    : 1.0  initial release
// ============================================================================
module object_motion_ctrl
  import vga_game_pkg::*;
#(
  parameter int DEB_CYCLES = 50000,
  parameter int FRAME_DIV  = 1,
  parameter int STEP       = 1,
  parameter int X_MIN      = X_MIN_DEF,
  parameter int X_MAX      = X_MAX_DEF,
  parameter int Y_MIN      = Y_MIN_DEF,
  parameter int Y_MAX      = Y_MAX_DEF,
  parameter int X_INIT     = 320,
  parameter int Y_INIT     = 240
) (
  input  wire logic           CLK,
  input  wire logic           RST,
  object_motion_ctrl_if.slave bus
);

  localparam int SW_UP    = 3;
  localparam int SW_DN    = 2;
  localparam int SW_LEFT  = 1;
  localparam int SW_RIGHT = 0;

  localparam logic [CALC_W-1:0] c_step   = CALC_W'(STEP);
  localparam logic [CALC_W-1:0] c_x_min  = CALC_W'(X_MIN);
  localparam logic [CALC_W-1:0] c_x_max  = CALC_W'(X_MAX);
  localparam logic [CALC_W-1:0] c_y_min  = CALC_W'(Y_MIN);
  localparam logic [CALC_W-1:0] c_y_max  = CALC_W'(Y_MAX);
  localparam logic [POS_W-1:0]  c_x_init = POS_W'(X_INIT);
  localparam logic [POS_W-1:0]  c_y_init = POS_W'(Y_INIT);
  localparam logic [7:0]        c_div_last = 8'(FRAME_DIV - 1);

  logic [3:0]       w_raw;
  logic [3:0]       w_deb;
  logic [3:0]       w_press;
  logic             w_tick;
  logic [POS_W-1:0] w_x_next;
  logic [POS_W-1:0] w_y_next;

  logic             r_vs_q;
  logic [0:0]       r_state;
  logic [7:0]       r_frame_cnt;
  logic [POS_W-1:0] r_x;
  logic [POS_W-1:0] r_y;
  logic             r_moving;

  assign w_raw = {bus.up_switch, bus.dn_switch, bus.left_switch, bus.right_switch};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_deb
      switch_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
      ) u_deb (
        .CLK      (CLK),
        .RST      (RST),
        .i_sw     (w_raw[gi]),
        .o_sw_deb (w_deb[gi])
      );
    end
  endgenerate

  assign w_press = ~w_deb;
  assign w_tick  = r_vs_q & ~bus.VS;

  assign w_x_next = axis_step(r_x, axis_cmd(w_press[SW_LEFT], w_press[SW_RIGHT]),
                              c_step, c_x_min, c_x_max);
  assign w_y_next = axis_step(r_y, axis_cmd(w_press[SW_UP], w_press[SW_DN]),
                              c_step, c_y_min, c_y_max);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vs_q      <= 1'b1;
      r_state     <= ST_WAIT;
      r_frame_cnt <= '0;
      r_x         <= c_x_init;
      r_y         <= c_y_init;
      r_moving    <= 1'b0;
    end else begin
      r_vs_q   <= bus.VS;
      r_moving <= 1'b0;
      case (r_state)
        ST_WAIT: begin
          if (w_tick) begin
            if (r_frame_cnt == c_div_last) begin
              r_frame_cnt <= '0;
              r_state     <= ST_APPLY;
            end else begin
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end
          end
        end
        ST_APPLY: begin
          r_x      <= w_x_next;
          r_y      <= w_y_next;
          r_moving <= (w_x_next != r_x) || (w_y_next != r_y);
          r_state  <= ST_WAIT;
        end
        default: r_state <= ST_WAIT;
      endcase
    end
  end

  assign bus.o_x    = r_x;
  assign bus.o_y    = r_y;
  assign bus.moving = r_moving;

  assign bus.at_edge[EDGE_LEFT]   = ({1'b0, r_x} == c_x_min);
  assign bus.at_edge[EDGE_RIGHT]  = ({1'b0, r_x} == c_x_max);
  assign bus.at_edge[EDGE_TOP]    = ({1'b0, r_y} == c_y_min);
  assign bus.at_edge[EDGE_BOTTOM] = ({1'b0, r_y} == c_y_max);

endmodule
`default_nettype wire

// File: tb/tb_object_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_object_motion_ctrl
//  Description : Directed and random switch/vsync stimulus against a frame
//                level reference of the object position.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_object_motion_ctrl;

  localparam int DEB_CYCLES = 4;
  localparam int FRAME_DIV  = 2;
  localparam int STEP       = 3;
  localparam int X_MIN      = 10;
  localparam int X_MAX      = 600;
  localparam int Y_MIN      = 10;
  localparam int Y_MAX      = 440;
  localparam int X_INIT     = 320;
  localparam int Y_INIT     = 240;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  object_motion_ctrl_if bus ();

  object_motion_ctrl #(
    .DEB_CYCLES (DEB_CYCLES),
    .FRAME_DIV  (FRAME_DIV),
    .STEP       (STEP),
    .X_MIN      (X_MIN),
    .X_MAX      (X_MAX),
    .Y_MIN      (Y_MIN),
    .Y_MAX      (Y_MAX),
    .X_INIT     (X_INIT),
    .Y_INIT     (Y_INIT)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: position, ticks since reset, debounced presses.
  int m_x, m_y, m_ticks;
  bit p_up, p_dn, p_l, p_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mstep(input int p, input bit dec, input bit inc, input int lo, input int hi);
    if (dec && !inc) return (p - STEP < lo) ? lo : p - STEP;
    if (inc && !dec) return (p + STEP > hi) ? hi : p + STEP;
    return p;
  endfunction

  function automatic logic [3:0] exp_edge();
    return {m_x == X_MIN, m_x == X_MAX, m_y == Y_MIN, m_y == Y_MAX};
  endfunction

  task automatic model_reset();
    m_x = X_INIT; m_y = Y_INIT; m_ticks = 0;
    p_up = 0; p_dn = 0; p_l = 0; p_r = 0;
  endtask

  task automatic set_sw(input bit up, input bit dn, input bit l, input bit r);
    bus.up_switch    = ~up;
    bus.dn_switch    = ~dn;
    bus.left_switch  = ~l;
    bus.right_switch = ~r;
    repeat (DEB_CYCLES + 6) @(posedge CLK);
    #1;
    p_up = up; p_dn = dn; p_l = l; p_r = r;
  endtask

  // One vsync low pulse; checks position before, at and after the update slot.
  task automatic frame();
    int nx, ny;
    bus.VS = 1'b0;
    @(posedge CLK); #1;
    chk("x_before_update", bus.o_x, m_x);
    m_ticks++;
    nx = m_x; ny = m_y;
    if (m_ticks % FRAME_DIV == 0) begin
      nx = mstep(m_x, p_l, p_r, X_MIN, X_MAX);
      ny = mstep(m_y, p_up, p_dn, Y_MIN, Y_MAX);
    end
    @(posedge CLK); #1;
    chk("x", bus.o_x, nx);
    chk("y", bus.o_y, ny);
    chk("moving", bus.moving, (nx != m_x) || (ny != m_y));
    m_x = nx; m_y = ny;
    chk("at_edge", bus.at_edge, exp_edge());
    bus.VS = 1'b1;
    @(posedge CLK); #1;
    chk("moving_one_cycle", bus.moving, 0);
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.VS = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_x", bus.o_x, X_INIT);
    chk("rst_y", bus.o_y, Y_INIT);
    chk("rst_moving", bus.moving, 0);
    chk("rst_at_edge", bus.at_edge, 4'b0000);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic reset_in_apply();
    for (int k = 0; k < FRAME_DIV && (m_ticks % FRAME_DIV) != FRAME_DIV - 1; k++) frame();
    bus.VS = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    bus.VS = 1'b1;
    @(posedge CLK); #1;
    chk("apply_rst_x", bus.o_x, X_INIT);
    chk("apply_rst_y", bus.o_y, Y_INIT);
    chk("apply_rst_moving", bus.moving, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.up_switch = 1'b1; bus.dn_switch = 1'b1;
    bus.left_switch = 1'b1; bus.right_switch = 1'b1;
    bus.VS = 1'b1;
    model_reset();
    @(posedge CLK); #1;
    do_reset();

    // Short glitches on right must not register.
    bus.right_switch = 1'b0; repeat (3) @(posedge CLK); #1;
    bus.right_switch = 1'b1; @(posedge CLK); #1;
    bus.right_switch = 1'b0; repeat (3) @(posedge CLK); #1;
    bus.right_switch = 1'b1; repeat (10) @(posedge CLK); #1;
    repeat (2) frame();
    chk("glitch_x", bus.o_x, X_INIT);

    // Held press: one step every FRAME_DIV ticks.
    set_sw(0, 0, 0, 1);
    repeat (2) frame();
    chk("held_right_x", bus.o_x, X_INIT + STEP);

    // Frame divider on the y axis.
    do_reset();
    set_sw(1, 0, 0, 0);
    repeat (6) frame();
    chk("div_y", bus.o_y, Y_INIT - 3 * STEP);

    // Right clamp.
    do_reset();
    set_sw(0, 0, 0, 1);
    repeat (200) frame();
    chk("clamp_x", bus.o_x, X_MAX);
    chk("clamp_edge", bus.at_edge, 4'b0100);

    // Opposing x presses with dn held.
    do_reset();
    set_sw(0, 1, 1, 1);
    repeat (10) frame();
    chk("oppose_x", bus.o_x, X_INIT);
    chk("oppose_y", bus.o_y, Y_INIT + 5 * STEP);

    // Reset landing on the update cycle; the divider must restart.
    reset_in_apply();
    set_sw(0, 0, 0, 1);
    frame();
    frame();
    chk("restart_x", bus.o_x, X_INIT + STEP);

    // Random hold patterns, long enough to reach every border.
    for (int seg = 0; seg < 30; seg++) begin
      logic [3:0] pat;
      int nfr;
      pat = 4'($urandom);
      nfr = $urandom_range(1, 60);
      if ($urandom_range(0, 7) == 0) do_reset();
      set_sw(pat[3], pat[2], pat[1], pat[0]);
      for (int f = 0; f < nfr; f++) frame();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/object_motion_ctrl.md
Name: object_motion_ctrl

Overview:
- Sequences position updates for the single on-screen game object in the 640x480 VGA game.
- Debounces the four active-low direction switches and applies at most one clamped step per N frames.
- Updates land only in vertical blank, on the VS falling edge, so the object never tears mid-frame.
- Sits between the switch pins / vga timing and the pixel compositor, and owns o_x/o_y.

Parameters:
- DEB_CYCLES, 50000: consecutive stable cycles before a debounced switch changes state (min 1).
- FRAME_DIV, 1: number of frame ticks per movement step (1..255).
- STEP, 1: pixels moved per step on each axis.
- X_MIN, 10: leftmost legal o_x (inside the border).
- X_MAX, 600: rightmost legal o_x (630 minus object size 30).
- Y_MIN, 10: topmost legal o_y.
- Y_MAX, 440: bottommost legal o_y (470 minus 30).
- X_INIT, 320: o_x after reset.
- Y_INIT, 240: o_y after reset.

Ports:
- CLK  in  1  pixel clock; vga timing runs on the same clock.
- RST  in  1  synchronous, active-high reset.
- up_switch  in  1  raw switch, active-low (0 = pressed).
- dn_switch  in  1  raw switch, active-low.
- left_switch  in  1  raw switch, active-low.
- right_switch  in  1  raw switch, active-low.
- VS  in  1  vertical sync from vga, active-low, same clock domain.
- o_x  out  10  object left edge.
- o_y  out  10  object top edge.
- moving  out  1  one-cycle pulse when o_x or o_y changes.
- at_edge  out  4  {left, right, top, bottom}: o_x==X_MIN, o_x==X_MAX, o_y==Y_MIN, o_y==Y_MAX.

Behaviour:
- Reset values: o_x=X_INIT, o_y=Y_INIT, moving=0, FSM=WAIT, frame counter=0, vs_q=1.
- Reset state of debouncers: all debounced outputs = released (1), counters = 0.
- Reset is honoured mid-APPLY; RST has priority over all updates.
- Switch input path: each switch goes through a 2-flop synchronizer, then the debouncer.
- Debounce rule: the debounced output takes the synchronized value only after it has differed from the current output for DEB_CYCLES consecutive cycles.
- Any glitch back to the current value clears that switch's counter.
- Frame tick: vs_q is VS registered; tick = vs_q & ~VS, one cycle per frame.
- Frame counter: counts ticks from 0 to FRAME_DIV-1.
- FSM state WAIT: on a tick with counter==FRAME_DIV-1, clear the counter and go to APPLY; on any other tick, increment the counter.
- FSM state APPLY (exactly one cycle): register new positions and pulse moving if either coordinate changed; return to WAIT.
- Latency: tick in cycle N -> APPLY in cycle N+1 -> new o_x/o_y visible in cycle N+2.
- Axis resolution: each axis is resolved independently.
- Up only: step -1 on y. Dn only: step +1 on y.
- Up and dn both pressed, or neither pressed: no y change. X axis (left/right) follows the same rules.
- Diagonal motion is allowed.
- Arithmetic is done 11 bits wide, so there is no wrap-around.
- Decrement: if pos >= MIN+STEP then pos-STEP, else MIN.
- Increment: if pos+STEP <= MAX then pos+STEP, else MAX.
- A value already at a limit holds; moving stays 0 for an axis held at its limit.
- Switch changes during APPLY have no effect until the next qualifying tick.
- at_edge is combinational from the o_x/o_y registers.

Decomposition:
- Package vga_game_pkg holds the screen constants: H_ACTIVE=640, V_ACTIVE=480, BORDER=10, OBJ_SIZE=30.
- It also holds the derived limits (X_MIN/X_MAX/Y_MIN/Y_MAX defaults), the FSM state encoding (WAIT, APPLY) and the direction bit indices of at_edge.
- Sub-module switch_debounce (synchronizer + stable counter, parameter DEB_CYCLES), instantiated 4x.

Test Plan:
- Reset check: RST high for 2 cycles -> o_x=320, o_y=240, moving=0, at_edge=0000.
- Debounce, DEB_CYCLES=4, FRAME_DIV=1: right_switch low for 3 cycles, then high, then low and held -> no motion from the 3-cycle glitch; after the held press and the next VS falling edge, o_x=321 exactly 2 cycles after the tick, with one moving pulse.
- Frame divider, FRAME_DIV=3: up_switch held for 9 VS falling edges -> o_y goes 240->237, changing only on ticks 3, 6 and 9.
- Clamp, STEP=4: start o_x=602 region by holding right -> o_x reaches 600 and holds; at_edge=0100; moving stays 0 on later ticks.
- Opposing presses: left and right both held, plus dn held, over 5 ticks -> o_x constant at 320, o_y=245.
- Reset mid-operation: assert RST in the APPLY cycle -> the next cycle shows o_x=320, o_y=240, moving=0, and the frame counter restarts from 0.
